// File: rtl/alu_seg_display.sv
// Captures the ALU result/status pair on a load strobe and shows it as two hex digits
// on a multiplexed common-anode seven-segment display. Define ALU_SEG_LZ_BLANK_EN to blank a zero high digit.
module alu_seg_display #(
  parameter int WIDTH       = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] result,
  input  logic             status,
  input  logic             load,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [1:0]       an,
  output logic             valid
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [1:0] AN_OFF    = 2'b11;
  localparam logic [1:0] AN_LOW    = 2'b10;
  localparam logic [1:0] AN_HIGH   = 2'b01;

  // Active-low gfedcba patterns for one hex nibble.
  function automatic logic [6:0] font(input logic [3:0] nib);
    case (nib)
      4'h0:    font = 7'h40;
      4'h1:    font = 7'h79;
      4'h2:    font = 7'h24;
      4'h3:    font = 7'h30;
      4'h4:    font = 7'h19;
      4'h5:    font = 7'h12;
      4'h6:    font = 7'h02;
      4'h7:    font = 7'h78;
      4'h8:    font = 7'h00;
      4'h9:    font = 7'h10;
      4'hA:    font = 7'h08;
      4'hB:    font = 7'h03;
      4'hC:    font = 7'h46;
      4'hD:    font = 7'h21;
      4'hE:    font = 7'h06;
      default: font = 7'h0E;
    endcase
  endfunction

  logic [7:0]       cap_val;
  logic             cap_stat;
  logic [CNT_W-1:0] cnt;
  logic             dig_sel;
  logic [6:0]       seg_d;
  logic             dp_d;
  logic [1:0]       an_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_val  <= '0;
      cap_stat <= 1'b0;
      valid    <= 1'b0;
    end else if (load) begin
      cap_val  <= 8'(result);
      cap_stat <= status;
      valid    <= 1'b1;
    end
  end

  // Scan runs free of valid so digit timing never depends on capture history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      dig_sel <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt     <= '0;
      dig_sel <= ~dig_sel;
    end else begin
      cnt     <= cnt + CNT_W'(1);
    end
  end

  // NOTE: blank defaults first keep this block free of inferred latches.
  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    an_d  = AN_OFF;
    if (valid) begin
      if (!dig_sel) begin
        an_d  = AN_LOW;
        seg_d = font(cap_val[3:0]);
        dp_d  = ~cap_stat;
      end else begin
`ifdef ALU_SEG_LZ_BLANK_EN
        if (cap_val[7:4] != 4'h0) begin
          an_d  = AN_HIGH;
          seg_d = font(cap_val[7:4]);
        end
`else
        an_d  = AN_HIGH;
        seg_d = font(cap_val[7:4]);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= AN_OFF;
    end else begin
      seg <= seg_d;
      dp  <= dp_d;
      an  <= an_d;
    end
  end

endmodule

// File: tb/tb_alu_seg_display.sv
// Randomized self-checking bench for alu_seg_display: three instances (4-bit, 8-bit,
// and REFRESH_DIV=1) compared every cycle against a cycle-count based reference model.
module tb_alu_seg_display;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic [3:0] res4   = '0;
  logic [7:0] res8   = '0;
  logic       status = 1'b0;
  logic       load   = 1'b0;

  logic [6:0] seg_o   [3];
  logic       dp_o    [3];
  logic [1:0] an_o    [3];
  logic       valid_o [3];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int GW = (g == 1) ? 8 : 4;
    localparam int GD = (g == 2) ? 1 : 4;
    logic [GW-1:0] res_g;
    assign res_g = (g == 1) ? GW'(res8) : GW'(res4);
    alu_seg_display #(.WIDTH(GW), .REFRESH_DIV(GD)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .result (res_g),
      .status (status),
      .load   (load),
      .seg    (seg_o[g]),
      .dp     (dp_o[g]),
      .an     (an_o[g]),
      .valid  (valid_o[g])
    );
  end

  // Reference model: the digit shown is a pure function of edges elapsed since reset.
  logic [6:0] font_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int         n_edges = 0;
  logic [7:0] m_val   [3] = '{8'h0, 8'h0, 8'h0};
  logic       m_stat  [3] = '{1'b0, 1'b0, 1'b0};
  logic       m_valid [3] = '{1'b0, 1'b0, 1'b0};
  logic [6:0] e_seg   [3] = '{7'h7F, 7'h7F, 7'h7F};
  logic       e_dp    [3] = '{1'b1, 1'b1, 1'b1};
  logic [1:0] e_an    [3] = '{2'b11, 2'b11, 2'b11};
  logic       e_valid [3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_edges = 0;
      for (int i = 0; i < 3; i++) begin
        m_val[i] = 8'h0; m_stat[i] = 1'b0; m_valid[i] = 1'b0;
        e_seg[i] = 7'h7F; e_dp[i] = 1'b1; e_an[i] = 2'b11; e_valid[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        int div;
        int dig;
        logic [3:0] hi;
        logic [3:0] lo;
        div = (i == 2) ? 1 : 4;
        dig = (n_edges / div) % 2;
        hi  = m_val[i] >> 4;
        lo  = m_val[i] % 16;
        e_seg[i] = 7'h7F; e_dp[i] = 1'b1; e_an[i] = 2'b11;
        if (m_valid[i] && dig == 0) begin
          e_an[i] = 2'b10; e_seg[i] = font_tbl[lo]; e_dp[i] = !m_stat[i];
        end else if (m_valid[i]) begin
`ifdef ALU_SEG_LZ_BLANK_EN
          if (hi != 0) begin e_an[i] = 2'b01; e_seg[i] = font_tbl[hi]; end
`else
          e_an[i] = 2'b01; e_seg[i] = font_tbl[hi];
`endif
        end
        if (load) begin
          m_val[i]   = (i == 1) ? res8 : {4'h0, res4};
          m_stat[i]  = status;
          m_valid[i] = 1'b1;
        end
        e_valid[i] = m_valid[i];
      end
      n_edges++;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("seg[%0d]", i),   8'(seg_o[i]),   8'(e_seg[i]));
        check($sformatf("dp[%0d]", i),    8'(dp_o[i]),    8'(e_dp[i]));
        check($sformatf("an[%0d]", i),    8'(an_o[i]),    8'(e_an[i]));
        check($sformatf("valid[%0d]", i), 8'(valid_o[i]), 8'(e_valid[i]));
      end
    end
  end

  // Bounded wait until instance idx shows (or stops showing) the given digit enable.
  task automatic wait_an(input int idx, input logic [1:0] target, input bit equal);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if ((an_o[idx] == target) == equal) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_an[%0d] timeout: an=%b, target=%b equal=%0d", idx, an_o[idx], target, equal);
    end
  endtask

  task automatic capture(input logic [3:0] r4, input logic [7:0] r8, input logic st);
    @(negedge clk);
    load = 1'b1; res4 = r4; res8 = r8; status = st;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    repeat (10) @(negedge clk);

    capture(4'hA, 8'h3F, 1'b0);
    wait_an(0, 2'b10, 1'b1);
    check("lit_A_lo_seg", 8'(seg_o[0]), 8'h08);
    check("lit_A_lo_dp",  8'(dp_o[0]),  8'h01);
    wait_an(0, 2'b10, 1'b0);
`ifdef ALU_SEG_LZ_BLANK_EN
    check("lit_A_hi_an",  8'(an_o[0]),  8'h03);
    check("lit_A_hi_seg", 8'(seg_o[0]), 8'h7F);
`else
    check("lit_A_hi_an",  8'(an_o[0]),  8'h01);
    check("lit_A_hi_seg", 8'(seg_o[0]), 8'h40);
`endif
    wait_an(1, 2'b10, 1'b1);
    check("lit_3F_lo_seg", 8'(seg_o[1]), 8'h0E);
    wait_an(1, 2'b01, 1'b1);
    check("lit_3F_hi_seg", 8'(seg_o[1]), 8'h30);

    capture(4'h0, 8'h00, 1'b1);
    wait_an(0, 2'b10, 1'b1);
    check("lit_zero_lo_seg", 8'(seg_o[0]), 8'h40);
    check("lit_zero_lo_dp",  8'(dp_o[0]),  8'h00);
    wait_an(0, 2'b10, 1'b0);
    check("lit_zero_hi_dp",  8'(dp_o[0]),  8'h01);

    @(negedge clk);
    load = 1'b1; res4 = 4'h1; res8 = 8'h01; status = 1'b0;
    @(negedge clk);
    res4 = 4'h2; res8 = 8'h02;
    @(negedge clk);
    res4 = 4'h3; res8 = 8'h03;
    @(negedge clk);
    load = 1'b0;
    repeat (6) @(negedge clk);

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      load   = ($urandom_range(0, 3) == 0);
      res4   = 4'($urandom);
      res8   = 8'($urandom);
      status = 1'($urandom);
    end
    @(negedge clk);
    load = 1'b0;

    capture(4'h5, 8'h5A, 1'b1);
    wait_an(0, 2'b10, 1'b1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_seg[%0d]", i),   8'(seg_o[i]),   8'h7F);
      check($sformatf("rst_an[%0d]", i),    8'(an_o[i]),    8'h03);
      check($sformatf("rst_dp[%0d]", i),    8'(dp_o[i]),    8'h01);
      check($sformatf("rst_valid[%0d]", i), 8'(valid_o[i]), 8'h00);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_an0", 8'(an_o[0]), 8'h03);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
